// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready intake and gap-free streaming.
// Optional trailing even-parity bit enabled by defining SER_PARITY_EN.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SER_PARITY_EN
    localparam logic [1:0] PARITY = 2'd2;
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             din_ready_q, din_ready_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             accept_c;
    logic             last_c;

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
`ifdef SER_PARITY_EN
        parity_d     = parity_q;
`endif
        din_ready_d  = 1'b0;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        accept_c = din_valid && din_ready_q;
        last_c   = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SHIFT: begin
                if (LSB_FIRST != 0) shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                else                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d = CW'(cnt_q + CW'(1));
                if (last_c) begin
`ifdef SER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An accept (only possible while din_ready_q) overrides the frame end.
        if (accept_c) begin
            shreg_d = din;
            cnt_d   = '0;
            state_d = SHIFT;
`ifdef SER_PARITY_EN
            parity_d = ^din;
`endif
        end

        case (state_d)
            IDLE: begin
                din_ready_d = 1'b1;
            end
            SHIFT: begin
                busy_d       = 1'b1;
                sout_valid_d = 1'b1;
                sout_d       = (LSB_FIRST != 0) ? shreg_d[0] : shreg_d[WIDTH-1];
`ifndef SER_PARITY_EN
                done_d      = (cnt_d == CW'(WIDTH - 1));
                din_ready_d = done_d;
`endif
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                busy_d       = 1'b1;
                sout_valid_d = 1'b1;
                sout_d       = parity_d;
                done_d       = 1'b1;
                din_ready_d  = 1'b1;
            end
`endif
            default: begin
                din_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            din_ready_q  <= 1'b1;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            din_ready_q  <= din_ready_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SER_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign din_ready  = din_ready_q;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: MSB-first and LSB-first instances share stimulus.
module tb_piso_serializer;

    localparam int unsigned W = 8;
`ifdef SER_PARITY_EN
    localparam int FL  = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FL  = W;
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clr;
    logic [W-1:0] din;
    logic         din_valid;

    logic m_din_ready, m_sout, m_sout_valid, m_busy, m_done;
    logic l_din_ready, l_sout, l_sout_valid, l_busy, l_done;

    int n_total = 0;
    int n_pass  = 0;
    bit mon_en  = 1'b0;

    // Each entry is {expected sout, expected done}.
    logic [1:0] q_m[$];
    logic [1:0] q_l[$];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(0)) u_msb (
        .clk(clk), .clr(clr), .din(din), .din_valid(din_valid),
        .din_ready(m_din_ready), .sout(m_sout), .sout_valid(m_sout_valid),
        .busy(m_busy), .done(m_done)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1)) u_lsb (
        .clk(clk), .clr(clr), .din(din), .din_valid(din_valid),
        .din_ready(l_din_ready), .sout(l_sout), .sout_valid(l_sout_valid),
        .busy(l_busy), .done(l_done)
    );

    function automatic void push_word(input logic [W-1:0] w);
        for (int i = 0; i < int'(W); i++) begin
            q_m.push_back({w[W-1-i], (i == int'(W) - 1) && !PAR});
            q_l.push_back({w[i],     (i == int'(W) - 1) && !PAR});
        end
        if (PAR) begin
            q_m.push_back({^w, 1'b1});
            q_l.push_back({^w, 1'b1});
        end
    endfunction

    // Pops the scoreboard whenever a frame bit is on the line; otherwise expects a quiet line.
    always @(negedge clk) begin
        logic [1:0] e;
        if (mon_en) begin
            n_total++;
            if (m_sout_valid) begin
                if (q_m.size() == 0) $display("FAIL msb_unexpected_bit got sout=%b expected no valid bit", m_sout);
                else begin
                    e = q_m.pop_front();
                    if ({m_sout, m_done} !== e) $display("FAIL msb_bit got sout,done=%b%b expected %b", m_sout, m_done, e);
                    else n_pass++;
                end
            end else if ({m_sout, m_done, m_busy} !== 3'b000)
                $display("FAIL msb_idle got sout,done,busy=%b%b%b expected 000", m_sout, m_done, m_busy);
            else n_pass++;

            n_total++;
            if (l_sout_valid) begin
                if (q_l.size() == 0) $display("FAIL lsb_unexpected_bit got sout=%b expected no valid bit", l_sout);
                else begin
                    e = q_l.pop_front();
                    if ({l_sout, l_done} !== e) $display("FAIL lsb_bit got sout,done=%b%b expected %b", l_sout, l_done, e);
                    else n_pass++;
                end
            end else if ({l_sout, l_done, l_busy} !== 3'b000)
                $display("FAIL lsb_idle got sout,done,busy=%b%b%b expected 000", l_sout, l_done, l_busy);
            else n_pass++;
        end
    end

    // Drive one cycle from a negedge; record accepts/clears at the posedge, return at next negedge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic c);
        logic rdy;
        din_valid = v;
        din       = d;
        clr       = c;
        rdy       = m_din_ready;
        @(posedge clk);
        if (c) begin
            q_m.delete();
            q_l.delete();
        end else if (v && rdy) begin
            push_word(d);
        end
        @(negedge clk);
    endtask

    task automatic check_frame_cycle(input string nm, input int k, input logic exp_valid,
                                     input logic exp_done, input logic exp_ready);
        n_total++;
        if ({m_sout_valid, m_busy, m_done, m_din_ready} !== {exp_valid, exp_valid, exp_done, exp_ready})
            $display("FAIL %s cycle %0d got valid,busy,done,ready=%b%b%b%b expected %b%b%b%b", nm, k,
                     m_sout_valid, m_busy, m_done, m_din_ready, exp_valid, exp_valid, exp_done, exp_ready);
        else n_pass++;
    endtask

    task automatic check_drained(input string nm);
        n_total++;
        if (q_m.size() != 0 || q_l.size() != 0)
            $display("FAIL %s_drained got %0d/%0d pending bits expected 0/0", nm, q_m.size(), q_l.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        step(1'b1, 8'hFF, 1'b1);
        mon_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if ({m_din_ready, m_sout_valid, m_busy, m_sout, l_din_ready} !== 5'b10001)
                $display("FAIL reset_state %0d got ready,valid,busy,sout=%b%b%b%b expected 1000",
                         k, m_din_ready, m_sout_valid, m_busy, m_sout);
            else n_pass++;
            step(k == 0 ? 1'b1 : 1'b0, 8'hFF, k == 0);
        end
        check_drained("reset");
    endtask

    task automatic test_single();
        step(1'b1, 8'hA5, 1'b0);
        for (int k = 1; k <= FL + 1; k++) begin
            check_frame_cycle("single", k, k <= FL, k == FL, k >= FL);
            step(1'b0, 8'h00, 1'b0);
        end
        check_drained("single");
    endtask

    task automatic test_back_to_back();
        step(1'b1, 8'hA5, 1'b0);
        for (int k = 1; k <= 2 * FL + 1; k++) begin
            check_frame_cycle("b2b", k, k <= 2 * FL, (k == FL) || (k == 2 * FL), (k == FL) || (k >= 2 * FL));
            step(k <= FL, 8'h3C, 1'b0);
        end
        check_drained("b2b");
    endtask

    task automatic test_busy_ignore_clr();
        step(1'b1, 8'hA5, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            check_frame_cycle("busy_ign", k, 1'b1, 1'b0, 1'b0);
            step(k >= 2, 8'h00, k == 4);
        end
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if ({m_sout, m_sout_valid, m_busy, m_done, m_din_ready} !== 5'b00001)
                $display("FAIL clr_abandon %0d got sout,valid,busy,done,ready=%b%b%b%b%b expected 00001",
                         k, m_sout, m_sout_valid, m_busy, m_done, m_din_ready);
            else n_pass++;
            step(1'b0, 8'h00, 1'b0);
        end
        step(1'b1, 8'h81, 1'b0);
        for (int k = 1; k <= FL + 1; k++) begin
            check_frame_cycle("after_clr", k, k <= FL, k == FL, k >= FL);
            step(1'b0, 8'h00, 1'b0);
        end
        check_drained("after_clr");
    endtask

    task automatic test_lsb_first();
        logic [W-1:0] words [2];
        words[0] = 8'h01;
        words[1] = 8'h80;
        for (int w = 0; w < 2; w++) begin
            step(1'b1, words[w], 1'b0);
            for (int k = 1; k <= FL + 1; k++) begin
                n_total++;
                if (l_sout_valid && k <= int'(W) && l_sout !== words[w][k-1])
                    $display("FAIL lsb_order word %0d bit %0d got %b expected %b", w, k, l_sout, words[w][k-1]);
                else if (l_sout_valid !== (k <= FL))
                    $display("FAIL lsb_valid word %0d cycle %0d got %b expected %b", w, k, l_sout_valid, k <= FL);
                else n_pass++;
                step(1'b0, 8'h00, 1'b0);
            end
        end
        check_drained("lsb");
    endtask

    task automatic test_parity();
        step(1'b1, 8'hA5, 1'b0);
        for (int k = 1; k <= 2 * FL + 1; k++) begin
            check_frame_cycle("parity", k, k <= 2 * FL, (k == FL) || (k == 2 * FL), (k == FL) || (k >= 2 * FL));
            step(k == FL, 8'h07, 1'b0);
        end
        check_drained("parity");
    endtask

    initial begin
        clr       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_ignore_clr();
        test_lsb_first();
        test_parity();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
